mc_core: RTL and testbench

Multi-cycle, parametrised successor to the single-cycle RV top level. It fetches one instruction at a time over a valid/ready-style fetch port, then decodes, executes and writes back in a dedicated state. It halts cleanly on EBREAK and traps on illegal instructions or misaligned jump targets. It sits between the instruction memory model and the simulation harness, which consumes the commit, halt and trap outputs for difftest and exit handling.

---
 rtl/mc_core.sv | 224 ++++++++++++++++++++++
 tb/tb_mc_core.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_core.sv
// Multi-cycle RV32I/RV64I subset core: fetch over a valid/ready port, then execute
// and retire in a single EXEC state. Stops on EBREAK (halt) or on an exception (trap).
module mc_core #(
  parameter int          XLEN     = 64,
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          NREGS    = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ifu_req_valid,
  output logic [XLEN-1:0] ifu_req_addr,
  input  logic            ifu_rsp_valid,
  input  logic [31:0]     ifu_rsp_inst,
  output logic [XLEN-1:0] current_pc,
  output logic            commit_valid,
  output logic [XLEN-1:0] commit_pc,
  output logic [31:0]     commit_inst,
  output logic            halted,
  output logic [XLEN-1:0] halt_code,
  output logic            trap,
  output logic [1:0]      trap_cause
);

  // state | meaning
  // FETCH | request pending at pc, waiting for the instruction word
  // EXEC  | decode/execute/writeback of the latched instruction
  // HALT  | EBREAK retired, core stopped until reset
  // TRAP  | exception taken, core stopped until reset
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT, S_TRAP} state_t;

  localparam int              RW      = $clog2(NREGS);
  localparam int              A0      = 10;
  localparam logic [XLEN-1:0] PC_INIT = RESET_PC[XLEN-1:0];

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [31:0] EBREAK  = 32'h0010_0073;

  state_t          state, state_next;
  logic [XLEN-1:0] pc;
  logic [31:0]     inst;
  logic [XLEN-1:0] rf [NREGS];

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  logic [RW-1:0]   rd_idx, rs1_idx, rs2_idx;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] imm_i, imm_u, imm_j;
  logic [XLEN-1:0] pc_plus4, wb_data, target, next_pc;
  logic            legal, regs_ok, use_rd, use_rs1, use_rs2;
  logic            is_jump, is_ebreak, illegal, misalign;

  // RV-E style register files: index bits above log2(NREGS) must be zero
  function automatic logic reg_ok(input logic [4:0] r);
    return (32'(r) >> RW) == 32'd0;
  endfunction

  assign current_pc    = pc;
  assign ifu_req_addr  = pc;
  assign ifu_req_valid = (state == S_FETCH) && !rst;

  assign opcode  = inst[6:0];
  assign rd      = inst[11:7];
  assign funct3  = inst[14:12];
  assign rs1     = inst[19:15];
  assign rs2     = inst[24:20];
  assign funct7  = inst[31:25];
  assign rd_idx  = rd[RW-1:0];
  assign rs1_idx = rs1[RW-1:0];
  assign rs2_idx = rs2[RW-1:0];

  assign rs1_val = (rs1_idx == '0) ? '0 : rf[rs1_idx];
  assign rs2_val = (rs2_idx == '0) ? '0 : rf[rs2_idx];

  assign imm_i = XLEN'($signed(inst[31:20]));
  assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

  assign pc_plus4 = pc + XLEN'(4);

  always_comb begin
    legal     = 1'b0;
    use_rd    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    is_jump   = 1'b0;
    is_ebreak = 1'b0;
    wb_data   = '0;
    target    = '0;
    case (opcode)
      OP_LUI: begin
        legal   = 1'b1;
        use_rd  = 1'b1;
        wb_data = imm_u;
      end
      OP_AUIPC: begin
        legal   = 1'b1;
        use_rd  = 1'b1;
        wb_data = pc + imm_u;
      end
      OP_JAL: begin
        legal   = 1'b1;
        use_rd  = 1'b1;
        is_jump = 1'b1;
        wb_data = pc_plus4;
        target  = pc + imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          legal   = 1'b1;
          use_rd  = 1'b1;
          use_rs1 = 1'b1;
          is_jump = 1'b1;
          wb_data = pc_plus4;
          target  = (rs1_val + imm_i) & ~XLEN'(1);
        end
      end
      OP_IMM: begin
        if (funct3 == 3'b000) begin
          legal   = 1'b1;
          use_rd  = 1'b1;
          use_rs1 = 1'b1;
          wb_data = rs1_val + imm_i;
        end
      end
      OP_REG: begin
        if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
          legal   = 1'b1;
          use_rd  = 1'b1;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
          wb_data = rs1_val + rs2_val;
        end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
          legal   = 1'b1;
          use_rd  = 1'b1;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
          wb_data = rs1_val - rs2_val;
        end
      end
      OP_SYS: begin
        if (inst == EBREAK) begin
          legal     = 1'b1;
          is_ebreak = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign regs_ok  = (!use_rd  || reg_ok(rd))  &&
                    (!use_rs1 || reg_ok(rs1)) &&
                    (!use_rs2 || reg_ok(rs2));
  assign illegal  = !(legal && regs_ok);
  // illegal takes priority, so a bad encoding never reports a misaligned target
  assign misalign = !illegal && is_jump && target[1];
  assign next_pc  = is_jump ? target : pc_plus4;

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: if (ifu_rsp_valid) state_next = S_EXEC;
      S_EXEC: begin
        if (illegal || misalign) state_next = S_TRAP;
        else if (is_ebreak)      state_next = S_HALT;
        else                     state_next = S_FETCH;
      end
      S_HALT:  state_next = S_HALT;
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= PC_INIT;
      inst         <= '0;
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      commit_inst  <= '0;
      halted       <= 1'b0;
      halt_code    <= '0;
      trap         <= 1'b0;
      trap_cause   <= 2'd0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      commit_valid <= 1'b0;
      if (state == S_FETCH && ifu_rsp_valid) inst <= ifu_rsp_inst;
      if (state == S_EXEC) begin
        if (illegal) begin
          trap       <= 1'b1;
          trap_cause <= 2'd1;
        end else if (misalign) begin
          trap       <= 1'b1;
          trap_cause <= 2'd2;
        end else begin
          commit_valid <= 1'b1;
          commit_pc    <= pc;
          commit_inst  <= inst;
          if (use_rd && rd_idx != '0) rf[rd_idx] <= wb_data;
          if (is_ebreak) begin
            // pc stays on the EBREAK so the harness sees where the core stopped
            halted    <= 1'b1;
            halt_code <= rf[A0];
          end else begin
            pc <= next_pc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mc_core.sv
// Scoreboard bench for mc_core: a 64-bit/32-reg instance and a 32-bit/16-reg
// instance share one memory responder; only the selected core is out of reset.
module tb_mc_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        rst_a, rst_b;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_inst  = 32'h0;

  assign rst_a = rst | sel;
  assign rst_b = rst | ~sel;

  logic        a_req, a_cv, a_halt, a_trap;
  logic [63:0] a_addr, a_pc, a_cpc, a_hcode;
  logic [31:0] a_cinst;
  logic [1:0]  a_cause;
  logic        b_req, b_cv, b_halt, b_trap;
  logic [31:0] b_addr, b_pc, b_cpc, b_hcode;
  logic [31:0] b_cinst;
  logic [1:0]  b_cause;

  mc_core #(.XLEN(64), .RESET_PC(64'h8000_0000), .NREGS(32)) dut_a (
    .clk(clk), .rst(rst_a),
    .ifu_req_valid(a_req), .ifu_req_addr(a_addr),
    .ifu_rsp_valid(rsp_valid), .ifu_rsp_inst(rsp_inst),
    .current_pc(a_pc), .commit_valid(a_cv), .commit_pc(a_cpc), .commit_inst(a_cinst),
    .halted(a_halt), .halt_code(a_hcode), .trap(a_trap), .trap_cause(a_cause));

  mc_core #(.XLEN(32), .RESET_PC(64'h8000_0000), .NREGS(16)) dut_b (
    .clk(clk), .rst(rst_b),
    .ifu_req_valid(b_req), .ifu_req_addr(b_addr),
    .ifu_rsp_valid(rsp_valid), .ifu_rsp_inst(rsp_inst),
    .current_pc(b_pc), .commit_valid(b_cv), .commit_pc(b_cpc), .commit_inst(b_cinst),
    .halted(b_halt), .halt_code(b_hcode), .trap(b_trap), .trap_cause(b_cause));

  logic        v_req, v_cv, v_halt, v_trap;
  logic [63:0] v_addr, v_pc, v_cpc, v_hcode;
  logic [31:0] v_cinst;
  logic [1:0]  v_cause;

  assign v_req   = sel ? b_req   : a_req;
  assign v_cv    = sel ? b_cv    : a_cv;
  assign v_halt  = sel ? b_halt  : a_halt;
  assign v_trap  = sel ? b_trap  : a_trap;
  assign v_addr  = sel ? {32'h0, b_addr}  : a_addr;
  assign v_pc    = sel ? {32'h0, b_pc}    : a_pc;
  assign v_cpc   = sel ? {32'h0, b_cpc}   : a_cpc;
  assign v_hcode = sel ? {32'h0, b_hcode} : a_hcode;
  assign v_cinst = sel ? b_cinst : a_cinst;
  assign v_cause = sel ? b_cause : a_cause;

  localparam logic [63:0] RPC    = 64'h8000_0000;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] JAL_8  = 32'h0080_00EF;  // jal x1, +8

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        halt;
    logic [63:0] code;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  logic [31:0] mem [logic [63:0]];
  int          lat = 0;
  int          tests = 0;
  int          fails = 0;
  longint      cyc = 0;
  longint      last_cyc = 0;
  bit          have_last = 1'b0;
  int          period = 2;
  int          wcnt = 0;
  logic [63:0] addr0 = 64'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    logic [31:0] i;
    i = imm;
    return {i[11:0], 5'(rs1), 3'b000, 5'(rd), 7'h13};
  endfunction

  function automatic logic [31:0] rtype(input logic [6:0] f7, input int rd, input int rs1, input int rs2);
    return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] utype(input logic [6:0] op, input int rd, input int imm20);
    logic [31:0] i;
    i = imm20;
    return {i[19:0], 5'(rd), op};
  endfunction

  function automatic logic [31:0] jalr(input int rd, input int rs1, input int imm);
    logic [31:0] i;
    i = imm;
    return {i[11:0], 5'(rs1), 3'b000, 5'(rd), 7'h67};
  endfunction

  task automatic exp_commit(input logic [63:0] pc, input logic [31:0] inst,
                            input logic halt, input logic [63:0] code);
    sbq.push_back('{pc, inst, halt, code});
  endtask

  // instruction memory with programmable response latency
  initial forever begin
    @(negedge clk);
    if (v_req) begin
      if (wcnt == 0) addr0 = v_addr;
      if (wcnt == lat) begin
        rsp_valid = 1'b1;
        rsp_inst  = mem.exists(v_addr) ? mem[v_addr] : 32'h0;
        if (lat > 0) check("fetch_addr_stable", v_addr, addr0);
        wcnt = 0;
      end else begin
        rsp_valid = 1'b0;
        wcnt++;
      end
    end else begin
      rsp_valid = 1'b0;
      wcnt = 0;
    end
  end

  // commit monitor
  initial forever begin
    @(negedge clk);
    if (v_cv) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_commit: got pc %h expected no commit", v_cpc);
      end else begin
        e = sbq.pop_front();
        check("commit_pc", v_cpc, e.pc);
        check("commit_inst", 64'(v_cinst), 64'(e.inst));
        check("halt_with_commit", 64'(v_halt), 64'(e.halt));
        if (e.halt) check("halt_code", v_hcode, e.code);
        if (have_last) check("commit_spacing", 64'(cyc - last_cyc), 64'(period));
        last_cyc  = cyc;
        have_last = 1'b1;
      end
    end
  end

  task automatic start(input bit s, input int l);
    @(posedge clk);
    #2;
    rst = 1'b1;
    sel = s;
    lat = l;
    period = l + 2;
    have_last = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", 64'(v_req), 64'd0);
    check("rst_commit_valid", 64'(v_cv), 64'd0);
    check("rst_halted", 64'(v_halt), 64'd0);
    check("rst_trap", 64'(v_trap), 64'd0);
    check("rst_trap_cause", 64'(v_cause), 64'd0);
    check("rst_halt_code", v_hcode, 64'd0);
    check("rst_pc", v_pc, RPC);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("first_req_valid", 64'(v_req), 64'd1);
    check("first_req_addr", v_addr, RPC);
  endtask

  task automatic run_stop(input string name);
    int n;
    n = 0;
    while (!(v_halt || v_trap) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no halt/trap expected stop within 300 cycles", name);
    end
    repeat (3) @(negedge clk);
    check({name, "_sb_drained"}, 64'(sbq.size()), 64'd0);
  endtask

  task automatic load_arith;
    mem.delete();
    mem[RPC]      = addi(1, 0, 5);
    mem[RPC + 4]  = addi(2, 1, -7);
    mem[RPC + 8]  = rtype(7'h00, 3, 1, 2);
    mem[RPC + 12] = rtype(7'h00, 10, 3, 0);
    mem[RPC + 16] = EBREAK;
    for (int i = 0; i < 4; i++) exp_commit(RPC + 64'(4 * i), mem[RPC + 64'(4 * i)], 1'b0, 64'h0);
    exp_commit(RPC + 16, EBREAK, 1'b1, 64'd3);
  endtask

  initial begin
    int busy;

    // arithmetic chain, zero latency then 3 wait cycles per fetch
    load_arith();
    start(1'b0, 0);
    run_stop("arith_lat0");
    check("arith_lat0_halted", 64'(v_halt), 64'd1);

    load_arith();
    start(1'b0, 3);
    run_stop("arith_lat3");
    check("arith_lat3_trap", 64'(v_trap), 64'd0);

    // EBREAK with a0 = 42, then the core must stay idle
    mem.delete();
    mem[RPC]     = addi(10, 0, 42);
    mem[RPC + 4] = EBREAK;
    exp_commit(RPC, mem[RPC], 1'b0, 64'h0);
    exp_commit(RPC + 4, EBREAK, 1'b1, 64'd42);
    start(1'b0, 0);
    run_stop("ebreak");
    busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (v_req) busy++;
    end
    check("halt_req_idle_cycles", 64'(busy), 64'd0);
    check("halt_sticky", 64'(v_halt), 64'd1);

    // all-zero word is illegal
    mem.delete();
    mem[RPC] = 32'h0;
    start(1'b0, 0);
    run_stop("illegal");
    check("illegal_trap", 64'(v_trap), 64'd1);
    check("illegal_cause", 64'(v_cause), 64'd1);
    check("illegal_pc", v_pc, RPC);
    check("illegal_req_idle", 64'(v_req), 64'd0);

    // JALR to 0x102 is misaligned
    mem.delete();
    mem[RPC] = jalr(1, 0, 'h102);
    start(1'b0, 0);
    run_stop("jalr_misalign");
    check("jalr_trap", 64'(v_trap), 64'd1);
    check("jalr_cause", 64'(v_cause), 64'd2);
    check("jalr_pc", v_pc, RPC);

    // JAL +8 skips a trap word; x1 = pc+4 exposed through a0
    mem.delete();
    mem[RPC]      = JAL_8;
    mem[RPC + 4]  = 32'h0;
    mem[RPC + 8]  = rtype(7'h00, 10, 1, 0);
    mem[RPC + 12] = EBREAK;
    exp_commit(RPC, JAL_8, 1'b0, 64'h0);
    exp_commit(RPC + 8, mem[RPC + 8], 1'b0, 64'h0);
    exp_commit(RPC + 12, EBREAK, 1'b1, 64'h8000_0004);
    start(1'b0, 0);
    run_stop("jal");

    // SUB, LUI sign extension and AUIPC combined into a0
    mem.delete();
    mem[RPC]      = addi(5, 0, 7);
    mem[RPC + 4]  = rtype(7'h20, 10, 0, 5);
    mem[RPC + 8]  = utype(7'h37, 6, 'h80000);
    mem[RPC + 12] = rtype(7'h00, 10, 10, 6);
    mem[RPC + 16] = utype(7'h17, 7, 1);
    mem[RPC + 20] = rtype(7'h00, 10, 10, 7);
    mem[RPC + 24] = EBREAK;
    for (int i = 0; i < 6; i++) exp_commit(RPC + 64'(4 * i), mem[RPC + 64'(4 * i)], 1'b0, 64'h0);
    exp_commit(RPC + 24, EBREAK, 1'b1, 64'h0000_0000_0000_1009);
    start(1'b0, 1);
    run_stop("upper_imm");

    // 32-bit, 16-register core
    mem.delete();
    mem[RPC]      = addi(1, 0, -1);
    mem[RPC + 4]  = rtype(7'h00, 2, 1, 1);
    mem[RPC + 8]  = rtype(7'h00, 10, 2, 0);
    mem[RPC + 12] = EBREAK;
    for (int i = 0; i < 3; i++) exp_commit(RPC + 64'(4 * i), mem[RPC + 64'(4 * i)], 1'b0, 64'h0);
    exp_commit(RPC + 12, EBREAK, 1'b1, 64'h0000_0000_FFFF_FFFE);
    start(1'b1, 0);
    run_stop("rv32e_wrap");

    mem.delete();
    mem[RPC] = addi(17, 0, 1);
    start(1'b1, 0);
    run_stop("rv32e_x17");
    check("rv32e_x17_trap", 64'(v_trap), 64'd1);
    check("rv32e_x17_cause", 64'(v_cause), 64'd1);
    check("rv32e_x17_pc", v_pc, RPC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected finish before 400000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
